aes_iter_engine: RTL
====================

// Module: aes_iter_engine
// PURPOSE
//   Sequential AES-128 encryption engine with valid/ready handshakes on input and output.
//   Executes AES rounds with key expansion on the fly, performing UNROLL rounds per clock.
//   Accepts one block at a time and returns ciphertext plus the final round key.
//   Sits between the block-source stream and the ciphertext sink; replaces combinational use of the core.
// PARAMETERS
//   UNROLL   1   AES rounds computed per clock; legal values 1,2,5,10 (others: elaboration $error)
//   BIG_END  1   1: byte 0 = bits [0:7] of [0:127] vectors; 0: byte 0 = bits [120:127]
// PORTS
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous reset, active low
//   in_valid   in   1    plain_text/key valid
//   in_ready   out  1    engine can accept a block
//   plain_text in   128  plaintext block [0:127]
//   key        in   128  cipher key [0:127]
//   out_valid  out  1    cipher_text/key_out valid
//   out_ready  in   1    sink accepts result
//   cipher_text out 128  ciphertext [0:127]
//   key_out    out  128  round-10 key (decryption start key)
//   busy       out  1    high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, out_valid=0, cipher_text=0, key_out=0, round ctr=0;
//     in_ready=0 while rst_n low, 1 in the first cycle after release. Reset mid-RUN/DONE aborts; result lost.
//   FSM: IDLE -> RUN on in_valid&in_ready; RUN -> DONE when round ctr reaches 10; DONE -> IDLE on out_ready.
//   in_ready = (state==IDLE) & rst_n; combinational from state only (no input dependency).
//   Accept edge: state_reg = plain_text ^ key; rk_reg = key; rnd = 0.
//   Each RUN edge: UNROLL successive rounds, rnd += UNROLL; round r (1..10): rk = expand(rk, rcon[r]);
//     SubBytes, ShiftRows, MixColumns (skipped when r==10), AddRoundKey(rk).
//   rcon = 01,02,04,08,10,20,40,80,1b,36.
//   When rnd reaches 10: cipher_text<=state, key_out<=rk, out_valid<=1, state DONE.
//   Latency: out_valid rises 10/UNROLL cycles after the accept cycle (10,5,2,1).
//   DONE: cipher_text/key_out/out_valid held stable until out_valid&out_ready edge;
//     then out_valid<=0, IDLE; next accept is possible one cycle later (throughput 1 block per 10/UNROLL+2 cycles).
//   out_ready while not out_valid: ignored. in_valid while in_ready=0: ignored; input not sampled.
//   Inputs are sampled only at the accept edge; later changes to plain_text/key do not affect the result.
//   cipher_text/key_out keep last result after handshake until the next completion (not cleared).
//   S-box: 256-entry ROM function; UNROLL copies of the round datapath (16 S-boxes + 4 key S-boxes each).
// TESTING
//   FIPS-197 C.1: pt=00112233445566778899aabbccddeeff, key=000102..0f -> ct=69c4e0d86a7b0430d8cdb78070b4c55a,
//     key_out=13111d7fe3944a17f307a78b4d2b30c5.
//   pt=54776F204F6E65204E696E652054776F, key=5468617473206D79204B756E67204675 -> ct=29c3505f571420f6402299b31a02d73a.
//   Latency per UNROLL in {1,2,5,10}: out_valid exactly 10/5/2/1 cycles after accept; same ct for each build.
//   Backpressure: out_ready=0 for 7 cycles -> outputs stable, in_ready=0 throughout; accept only after handshake.
//   Input change: modify pt/key 1 cycle after accept -> ct matches originally accepted values.
//   Reset mid-RUN at round 4 -> next cycle out_valid=0, busy=0; post-release block gives correct ct.

Source files
------------

// File: rtl/aes_iter_engine.sv
// aes_iter_engine: iterative AES-128 encryption engine with valid/ready handshakes.
//   Computes UNROLL rounds per clock with on-the-fly key expansion and returns the
//   ciphertext together with the round-10 key (the start key for decryption).
// Ports:
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   in_valid / in_ready     input handshake for plain_text and key
//   plain_text, key         128-bit input block and cipher key
//   out_valid / out_ready   output handshake for cipher_text and key_out
//   cipher_text, key_out    128-bit result and final round key (held until next completion)
//   busy                    high while a block is in flight or awaiting handshake
// Parameters:
//   UNROLL   rounds per clock (1, 2, 5 or 10)
//   BIG_END  1: byte 0 is bits [0:7] of the vectors; 0: byte 0 is bits [120:127]
module aes_iter_engine #(
    parameter int unsigned UNROLL  = 1,
    parameter bit          BIG_END = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] plain_text,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] cipher_text,
    output logic [0:127] key_out,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_iter_engine: UNROLL must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Byte x of the S-box lives at bits [8x +: 8].
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Internal blocks use [127:0] with byte 0 in [127:120]; this reverses byte order.
    function automatic logic [127:0] swap_bytes(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = v[127-8*i -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] to_int(input logic [0:127] v);
        logic [127:0] s;
        s = v;
        return BIG_END ? s : swap_bytes(s);
    endfunction

    function automatic logic [0:127] to_port(input logic [127:0] s);
        logic [0:127] v;
        v = BIG_END ? s : swap_bytes(s);
        return v;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // SubBytes and ShiftRows: output (row r, col c) takes input (row r, col c+r).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] ko_q, ko_d;
    logic         ov_q, ov_d;
    logic [127:0] round_state, round_key;

    // UNROLL chained copies of the round datapath, starting at round rnd_q + 1.
    always_comb begin
        logic [127:0] st_v, rk_v, t_v;
        logic [3:0]   r_v;
        st_v = st_q;
        rk_v = rk_q;
        for (int k = 0; k < UNROLL; k++) begin
            r_v  = rnd_q + 4'(k + 1);
            rk_v = expand_key(rk_v, rcon(r_v));
            t_v  = sub_shift(st_v);
            if (r_v != 4'd10) begin
                t_v = mix_columns(t_v);
            end
            st_v = t_v ^ rk_v;
        end
        round_state = st_v;
        round_key   = rk_v;
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        ko_d    = ko_q;
        ov_d    = ov_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    st_d    = to_int(plain_text) ^ to_int(key);
                    rk_d    = to_int(key);
                    rnd_d   = 4'd0;
                end
            end
            StRun: begin
                st_d  = round_state;
                rk_d  = round_key;
                rnd_d = rnd_q + 4'(UNROLL);
                if (rnd_d == 4'd10) begin
                    state_d = StDone;
                    ct_d    = round_state;
                    ko_d    = round_key;
                    ov_d    = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    ov_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            st_q    <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            ct_q    <= '0;
            ko_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
            ko_q    <= ko_d;
            ov_q    <= ov_d;
        end
    end

    // rst_n gates in_ready so nothing is offered while reset is asserted.
    assign in_ready    = (state_q == StIdle) & rst_n;
    assign busy        = (state_q != StIdle);
    assign out_valid   = ov_q;
    assign cipher_text = to_port(ct_q);
    assign key_out     = to_port(ko_q);

endmodule
